// File: rtl/thread_scheduler.sv
// thread_scheduler
//   Chooses the hardware thread that drives fetch each cycle. A thread is
//   parked in WAIT while its cache miss refills. The scheduler flushes the
//   missing thread's younger instructions and raises stall_all only when
//   no thread can run.
//
//   Optional feature macro: SCHED_SWITCH_ON_MISS_EN
//     undefined : fine-grained round-robin, advancing every cycle
//     defined   : coarse-grained mode. Fetch stays on the current thread
//                 until it misses or is disabled.
//
//   Ports
//     clk, nReset            clock, asynchronous active-low reset
//     ThreadEnable[N]        software run mask
//     CacheMiss / MissTid    one-cycle miss report
//     Ready / ReadyTid       one-cycle refill-complete report
//     Hold                   freezes rotation while the current thread runs
//     FetchTid / FetchValid  selected thread; valid when not stalled
//     Flush / FlushTid       one-cycle squash of the missing thread
//     stall_all              no runnable thread
//     Blocked[N]             per-thread WAIT status

// Per-thread RUN/WAIT state. A same-cycle Ready re-opens the thread, so a
// miss arriving with that Ready counts as a fresh, accepted miss.
module thread_state (
  input  logic clk,
  input  logic nReset,
  input  logic miss_hit,
  input  logic ready_hit,
  output logic blocked,
  output logic blocked_next,
  output logic miss_acc
);
  assign miss_acc     = miss_hit && (!blocked || ready_hit);
  assign blocked_next = miss_hit || (blocked && !ready_hit);

  always_ff @(posedge clk or negedge nReset)
    if (!nReset) blocked <= 1'b0;
    else         blocked <= blocked_next;
endmodule

module thread_scheduler #(
  parameter  int NUM_THREADS = 4,
  localparam int TID_W       = $clog2(NUM_THREADS)
) (
  input  logic                   clk,
  input  logic                   nReset,
  input  logic [NUM_THREADS-1:0] ThreadEnable,
  input  logic                   CacheMiss,
  input  logic [TID_W-1:0]       MissTid,
  input  logic                   Ready,
  input  logic [TID_W-1:0]       ReadyTid,
  input  logic                   Hold,
  output logic [TID_W-1:0]       FetchTid,
  output logic                   FetchValid,
  output logic                   Flush,
  output logic [TID_W-1:0]       FlushTid,
  output logic                   stall_all,
  output logic [NUM_THREADS-1:0] Blocked
);

  typedef enum logic {SCHED, ALL_BLOCKED} state_t;
  state_t state;

  logic [NUM_THREADS-1:0] blocked_next, miss_acc, runnable_next;
  logic                   any_run, miss_any, keep_cur;
  logic [TID_W-1:0]       rr_tid, cand, next_tid;
  logic                   rr_found;

  for (genvar i = 0; i < NUM_THREADS; i++) begin : g_thr
    thread_state u_thr (
      .clk          (clk),
      .nReset       (nReset),
      .miss_hit     (CacheMiss && (MissTid == TID_W'(i))),
      .ready_hit    (Ready && (ReadyTid == TID_W'(i))),
      .blocked      (Blocked[i]),
      .blocked_next (blocked_next[i]),
      .miss_acc     (miss_acc[i])
    );
  end

  assign runnable_next = ThreadEnable & ~blocked_next;
  assign any_run       = |runnable_next;
  assign miss_any      = |miss_acc;

  // Round-robin search starting one past the current thread. The last
  // candidate (offset NUM_THREADS) wraps back to the current thread, so it
  // is picked only when it is the sole runnable one.
  always_comb begin
    rr_tid   = FetchTid;
    rr_found = 1'b0;
    cand     = FetchTid;
    for (int k = 1; k <= NUM_THREADS; k++) begin
      cand = FetchTid + TID_W'(k);
      if (!rr_found && runnable_next[cand]) begin
        rr_tid   = cand;
        rr_found = 1'b1;
      end
    end
  end

  // Staying on the current thread is only meaningful while scheduling. On
  // exit from ALL_BLOCKED the search always restarts past FetchTid.
`ifdef SCHED_SWITCH_ON_MISS_EN
  assign keep_cur = (state == SCHED) && runnable_next[FetchTid];
`else
  assign keep_cur = (state == SCHED) && Hold && runnable_next[FetchTid];
`endif

  assign next_tid = (!any_run || keep_cur) ? FetchTid : rr_tid;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state      <= ALL_BLOCKED;
      FetchTid   <= TID_W'(NUM_THREADS - 1);
      FetchValid <= 1'b0;
      stall_all  <= 1'b1;
      Flush      <= 1'b0;
      FlushTid   <= '0;
    end else begin
      FetchTid <= next_tid;
      Flush    <= miss_any;
      if (miss_any) FlushTid <= MissTid;
      case (state)
        SCHED:
          if (!any_run) begin
            state      <= ALL_BLOCKED;
            stall_all  <= 1'b1;
            FetchValid <= 1'b0;
          end
        ALL_BLOCKED:
          if (any_run) begin
            state      <= SCHED;
            stall_all  <= 1'b0;
            FetchValid <= 1'b1;
          end
      endcase
    end
  end

endmodule
